// File: rtl/hbridge_pwm_driver_if.sv
// Bundle between the steering controller and the H-bridge driver: direction and
// enable commands plus speed limit in, bridge pin drives and per-channel status out.
interface hbridge_pwm_driver_if #(
    parameter int PWM_BITS = 8
);
    logic [3:0]          motor_in;
    logic [1:0]          motor_en;
    logic [PWM_BITS-1:0] duty_limit;
    logic [3:0]          hb_in;
    logic [1:0]          hb_en;
    logic [1:0]          busy;

    modport master (
        output motor_in, motor_en, duty_limit,
        input  hb_in, hb_en, busy
    );

    modport slave (
        input  motor_in, motor_en, duty_limit,
        output hb_in, hb_en, busy
    );
endinterface

// File: rtl/hbridge_pwm_driver.sv
// Dual-channel L298-style H-bridge driver: break-before-make dead time on reversal,
// soft-start duty ramp, PWM speed limiting and brake/coast, with registered pin drives.
module hbridge_pwm_driver #(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 50,
    parameter int RAMP_DIV    = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hbridge_pwm_driver_if.slave  bus
);

    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int RAMP_W = $clog2(RAMP_DIV + 1);
    localparam logic [PWM_BITS-1:0] PWM_TOP   = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [DEAD_W-1:0]   DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
    localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(1);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {COAST, DEAD, DRIVE, BRAKE} state_t;
    typedef enum logic [1:0] {REQ_COAST, REQ_BRAKE, REQ_DRIVE} req_t;

    logic [3:0]          in_meta, in_sync;
    logic [1:0]          en_meta, en_sync;
    logic [PWM_BITS-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_meta <= '0;
            in_sync <= '0;
            en_meta <= '0;
            en_sync <= '0;
            cnt     <= '0;
        end else begin
            in_meta <= bus.motor_in;
            in_sync <= in_meta;
            en_meta <= bus.motor_en;
            en_sync <= en_meta;
            cnt     <= cnt_nxt;
        end
    end

    // Period is 2^PWM_BITS-1 so a duty of all-ones is genuinely 100% on.
    assign cnt_nxt = (cnt == PWM_TOP) ? '0 : cnt + 1'b1;

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        state_t              state, state_nxt;
        req_t                req;
        logic [1:0]          code;
        logic [1:0]          dir, dir_nxt;
        logic [DEAD_W-1:0]   dead_cnt, dead_nxt;
        logic [PWM_BITS-1:0] duty_cur, duty_nxt;
        logic [RAMP_W-1:0]   ramp_cnt, ramp_nxt;
        logic                pwm_on;
        logic [1:0]          pins_q, pins_nxt;
        logic                en_q, en_nxt;
        logic                busy_q, busy_nxt;

        assign code = in_sync[2*ch +: 2];

        always_comb begin
            if (!en_sync[ch] || code == 2'b00) begin
                req = REQ_COAST;
            end else if (code == 2'b11) begin
                req = REQ_BRAKE;
            end else begin
                req = REQ_DRIVE;
            end
        end

        always_comb begin
            state_nxt = state;
            dir_nxt   = dir;
            dead_nxt  = dead_cnt;
            duty_nxt  = '0;
            ramp_nxt  = '0;
            case (state)
                COAST: begin
                    if (req == REQ_DRIVE) begin
                        state_nxt = DEAD;
                        dir_nxt   = code;
                        dead_nxt  = DEAD_LOAD;
                    end else if (req == REQ_BRAKE) begin
                        state_nxt = BRAKE;
                    end
                end
                DEAD: begin
                    if (req == REQ_COAST) begin
                        state_nxt = COAST;
                    end else if (req == REQ_BRAKE) begin
                        state_nxt = BRAKE;
                    end else if (code != dir) begin
                        dir_nxt  = code;
                        dead_nxt = DEAD_LOAD;
                    end else if (dead_cnt <= DEAD_LAST) begin
                        state_nxt = DRIVE;
                        dead_nxt  = '0;
                    end else begin
                        dead_nxt = dead_cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (req == REQ_COAST) begin
                        state_nxt = COAST;
                    end else if (req == REQ_BRAKE) begin
                        state_nxt = BRAKE;
                    end else if (code != dir) begin
                        state_nxt = DEAD;
                        dir_nxt   = code;
                        dead_nxt  = DEAD_LOAD;
                    end else if (bus.duty_limit < duty_cur) begin
                        duty_nxt = bus.duty_limit;
                    end else if (duty_cur < bus.duty_limit) begin
                        if (ramp_cnt == RAMP_LAST) begin
                            duty_nxt = duty_cur + 1'b1;
                        end else begin
                            duty_nxt = duty_cur;
                            ramp_nxt = ramp_cnt + 1'b1;
                        end
                    end else begin
                        duty_nxt = duty_cur;
                    end
                end
                BRAKE: begin
                    if (req == REQ_DRIVE) begin
                        state_nxt = DEAD;
                        dir_nxt   = code;
                        dead_nxt  = DEAD_LOAD;
                    end else if (req == REQ_COAST) begin
                        state_nxt = COAST;
                    end
                end
                default: state_nxt = COAST;
            endcase
        end

        // Pins are decoded from next-state values so the registered drives never glitch.
        assign pwm_on = (cnt_nxt < duty_nxt);

        always_comb begin
            pins_nxt = 2'b00;
            en_nxt   = 1'b0;
            busy_nxt = 1'b0;
            case (state_nxt)
                DEAD: busy_nxt = 1'b1;
                DRIVE: begin
                    en_nxt   = 1'b1;
                    pins_nxt = pwm_on ? dir_nxt : 2'b00;
                    busy_nxt = (duty_nxt < bus.duty_limit);
                end
                BRAKE: begin
                    en_nxt   = 1'b1;
                    pins_nxt = 2'b11;
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= COAST;
                dir      <= '0;
                dead_cnt <= '0;
                duty_cur <= '0;
                ramp_cnt <= '0;
                pins_q   <= '0;
                en_q     <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                state    <= state_nxt;
                dir      <= dir_nxt;
                dead_cnt <= dead_nxt;
                duty_cur <= duty_nxt;
                ramp_cnt <= ramp_nxt;
                pins_q   <= pins_nxt;
                en_q     <= en_nxt;
                busy_q   <= busy_nxt;
            end
        end
    end

    assign bus.hb_in = {g_chan[1].pins_q, g_chan[0].pins_q};
    assign bus.hb_en = {g_chan[1].en_q, g_chan[0].en_q};
    assign bus.busy  = {g_chan[1].busy_q, g_chan[0].busy_q};

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Bench for hbridge_pwm_driver: directed vector table, hand sequences for PWM duty and
// reset-during-dead-time, and randomized commands checked against a cycle reference model.
module tb_hbridge_pwm_driver;

    localparam int PWM_BITS    = 4;
    localparam int DEAD_CYCLES = 4;
    localparam int RAMP_DIV    = 2;
    localparam int PERIOD      = (1 << PWM_BITS) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_RUN   = 2;
    localparam int M_BRAKE = 3;

    typedef struct {
        string      name;
        logic [3:0] m_in;
        logic [1:0] m_en;
        logic [3:0] limit;
        int         hold;
        logic       chk_pins;
        logic [3:0] exp_in;
        logic [1:0] exp_en;
        logic [1:0] exp_busy;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    hbridge_pwm_driver_if #(.PWM_BITS(PWM_BITS)) bus ();

    hbridge_pwm_driver #(
        .PWM_BITS   (PWM_BITS),
        .DEAD_CYCLES(DEAD_CYCLES),
        .RAMP_DIV   (RAMP_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what each channel is doing, from the command history.
    int         m_mode [2];
    logic [1:0] m_dir [2];
    int         m_wait [2];
    int         m_duty [2];
    int         m_ramp [2];
    logic [3:0] pipe_in [2];
    logic [1:0] pipe_en [2];
    int         edge_n;
    logic [7:0] exp_out;
    logic [3:0] prev_pins;

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = M_IDLE;
            m_dir[c]  = 2'b00;
            m_wait[c] = 0;
            m_duty[c] = 0;
            m_ramp[c] = 0;
            pipe_in[c] = 4'b0000;
            pipe_en[c] = 2'b00;
        end
        edge_n    = 0;
        exp_out   = 8'h00;
        prev_pins = 4'b0000;
    endtask

    task automatic modelStep();
        logic [3:0] used_in;
        logic [1:0] used_en;
        logic [1:0] code;
        int         lim;
        int         phase;
        used_in    = pipe_in[1];
        used_en    = pipe_en[1];
        pipe_in[1] = pipe_in[0];
        pipe_en[1] = pipe_en[0];
        pipe_in[0] = bus.motor_in;
        pipe_en[0] = bus.motor_en;
        lim        = int'(bus.duty_limit);
        edge_n     = edge_n + 1;
        phase      = edge_n % PERIOD;
        exp_out    = 8'h00;
        for (int c = 0; c < 2; c++) begin
            bit drive_w, brake_w, coast_w;
            code    = used_in[2*c +: 2];
            drive_w = used_en[c] && (code == 2'b01 || code == 2'b10);
            brake_w = used_en[c] && (code == 2'b11);
            coast_w = !drive_w && !brake_w;
            case (m_mode[c])
                M_IDLE: begin
                    if (drive_w) begin
                        m_mode[c] = M_WAIT; m_dir[c] = code; m_wait[c] = DEAD_CYCLES;
                    end else if (brake_w) m_mode[c] = M_BRAKE;
                end
                M_WAIT: begin
                    if (coast_w) m_mode[c] = M_IDLE;
                    else if (brake_w) m_mode[c] = M_BRAKE;
                    else if (code != m_dir[c]) begin
                        m_dir[c] = code; m_wait[c] = DEAD_CYCLES;
                    end else begin
                        m_wait[c] = m_wait[c] - 1;
                        if (m_wait[c] == 0) begin
                            m_mode[c] = M_RUN; m_duty[c] = 0; m_ramp[c] = 0;
                        end
                    end
                end
                M_RUN: begin
                    if (coast_w) m_mode[c] = M_IDLE;
                    else if (brake_w) m_mode[c] = M_BRAKE;
                    else if (code != m_dir[c]) begin
                        m_mode[c] = M_WAIT; m_dir[c] = code; m_wait[c] = DEAD_CYCLES;
                    end else if (m_duty[c] > lim) begin
                        m_duty[c] = lim; m_ramp[c] = 0;
                    end else if (m_duty[c] < lim) begin
                        m_ramp[c] = m_ramp[c] + 1;
                        if (m_ramp[c] == RAMP_DIV) begin
                            m_duty[c] = m_duty[c] + 1; m_ramp[c] = 0;
                        end
                    end else m_ramp[c] = 0;
                end
                default: begin
                    if (drive_w) begin
                        m_mode[c] = M_WAIT; m_dir[c] = code; m_wait[c] = DEAD_CYCLES;
                    end else if (coast_w) m_mode[c] = M_IDLE;
                end
            endcase
            if (m_mode[c] != M_RUN) m_duty[c] = 0;
            // exp_out = {hb_in[3:0], hb_en[1:0], busy[1:0]}
            case (m_mode[c])
                M_WAIT: exp_out[c] = 1'b1;
                M_RUN: begin
                    exp_out[2 + c] = 1'b1;
                    if (phase < m_duty[c]) exp_out[4 + 2*c +: 2] = m_dir[c];
                    exp_out[c] = (m_duty[c] < lim);
                end
                M_BRAKE: begin
                    exp_out[2 + c] = 1'b1;
                    exp_out[4 + 2*c +: 2] = 2'b11;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        logic [7:0] got;
        logic       bad;
        @(posedge clk);
        modelStep();
        #1;
        got = {bus.hb_in, bus.hb_en, bus.busy};
        n_cmp++;
        if (got !== exp_out) begin
            n_bad++;
            $display("[TB] FAIL model @%0t: got {hb_in,hb_en,busy}=%b want %b", $time, got, exp_out);
        end
        bad = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if ((prev_pins[2*c +: 2] == 2'b10 && bus.hb_in[2*c +: 2] == 2'b01) ||
                (prev_pins[2*c +: 2] == 2'b01 && bus.hb_in[2*c +: 2] == 2'b10)) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("[TB] FAIL direct_reversal @%0t: got hb_in %b after %b, want a 00 gap", $time, bus.hb_in, prev_pins);
        end
        prev_pins = bus.hb_in;
    endtask

    task automatic applyStimulus(input logic [3:0] m_in, input logic [1:0] m_en, input logic [3:0] limit);
        bus.motor_in   = m_in;
        bus.motor_en   = m_en;
        bus.duty_limit = limit;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_in, input logic [1:0] e_en,
                               input logic [1:0] e_busy, input logic chk_pins);
        n_cmp++;
        if ((chk_pins && bus.hb_in !== e_in) || bus.hb_en !== e_en || bus.busy !== e_busy) begin
            n_bad++;
            $display("[TB] FAIL %s: got hb_in=%b hb_en=%b busy=%b, want hb_in=%b hb_en=%b busy=%b",
                     name, bus.hb_in, bus.hb_en, bus.busy, e_in, e_en, e_busy);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic measureDuty(input string name, input int want);
        int hi_l, hi_r;
        hi_l = 0;
        hi_r = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            if (bus.hb_in[3]) hi_l++;
            if (bus.hb_in[1]) hi_r++;
        end
        checkCount({name, "_left"}, hi_l, want);
        checkCount({name, "_right"}, hi_r, want);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl [16];
        tbl[0]  = '{"idle",      4'b0000, 2'b00, 4'd15, 10, 1'b1, 4'b0000, 2'b00, 2'b00};
        tbl[1]  = '{"dead_a",    4'b1010, 2'b11, 4'd15,  3, 1'b1, 4'b0000, 2'b00, 2'b11};
        tbl[2]  = '{"dead_b",    4'b1010, 2'b11, 4'd15,  3, 1'b1, 4'b0000, 2'b00, 2'b11};
        tbl[3]  = '{"drv_entry", 4'b1010, 2'b11, 4'd15,  1, 1'b1, 4'b0000, 2'b11, 2'b11};
        tbl[4]  = '{"ramping",   4'b1010, 2'b11, 4'd15, 29, 1'b0, 4'b0000, 2'b11, 2'b11};
        tbl[5]  = '{"full",      4'b1010, 2'b11, 4'd15,  1, 1'b1, 4'b1010, 2'b11, 2'b00};
        tbl[6]  = '{"rev_lat",   4'b0101, 2'b11, 4'd15,  2, 1'b1, 4'b1010, 2'b11, 2'b00};
        tbl[7]  = '{"rev_dead",  4'b0101, 2'b11, 4'd15,  1, 1'b1, 4'b0000, 2'b00, 2'b11};
        tbl[8]  = '{"rev_dead4", 4'b0101, 2'b11, 4'd15,  3, 1'b1, 4'b0000, 2'b00, 2'b11};
        tbl[9]  = '{"rev_entry", 4'b0101, 2'b11, 4'd15,  1, 1'b1, 4'b0000, 2'b11, 2'b11};
        tbl[10] = '{"rev_full",  4'b0101, 2'b11, 4'd15, 30, 1'b1, 4'b0101, 2'b11, 2'b00};
        tbl[11] = '{"brake",     4'b1111, 2'b11, 4'd15,  3, 1'b1, 4'b1111, 2'b11, 2'b00};
        tbl[12] = '{"coast",     4'b0000, 2'b11, 4'd15,  3, 1'b1, 4'b0000, 2'b00, 2'b00};
        tbl[13] = '{"en_off",    4'b1010, 2'b00, 4'd15,  5, 1'b1, 4'b0000, 2'b00, 2'b00};
        tbl[14] = '{"steady",    4'b1010, 2'b11, 4'd15, 38, 1'b1, 4'b1010, 2'b11, 2'b00};
        tbl[15] = '{"limit8",    4'b1010, 2'b11, 4'd8,   1, 1'b0, 4'b0000, 2'b11, 2'b00};

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        applyStimulus(4'b0000, 2'b00, 4'd15);
        modelReset();
        #1;
        checkOutput("reset_state", 4'b0000, 2'b00, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].m_in, tbl[i].m_en, tbl[i].limit);
            repeat (tbl[i].hold) tick();
            checkOutput(tbl[i].name, tbl[i].exp_in, tbl[i].exp_en, tbl[i].exp_busy, tbl[i].chk_pins);
        end

        measureDuty("duty8", 8);
        applyStimulus(4'b1010, 2'b11, 4'd3);
        tick();
        checkOutput("limit3_snap", 4'b0000, 2'b11, 2'b00, 1'b0);
        measureDuty("duty3", 3);

        // Reversal requested, then reset lands in the middle of the dead time.
        applyStimulus(4'b0101, 2'b11, 4'd15);
        repeat (4) tick();
        checkOutput("pre_reset_dead", 4'b0000, 2'b00, 2'b11, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 2'b00, 2'b00, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
        repeat (3) tick();
        checkOutput("post_reset_dead1", 4'b0000, 2'b00, 2'b11, 1'b1);
        repeat (3) tick();
        checkOutput("post_reset_dead4", 4'b0000, 2'b00, 2'b11, 1'b1);
        tick();
        checkOutput("post_reset_drive", 4'b0000, 2'b11, 2'b11, 1'b1);

        for (int s = 0; s < 200; s++) begin
            logic [1:0] en_r;
            en_r = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            applyStimulus(4'($urandom), en_r, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(1, 25)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
